// File: rtl/rf2d_window.sv
// Row-shifting 2D register window: fills NUM_ROW rows, then scans the oldest WIN rows column by column.
// Optional registered window sum on out_sum when RF2D_WIN_SUM_EN is defined.
module rf2d_window #(
    parameter int NUM_COL = 18,
    parameter int NUM_ROW = 16,
    parameter int DATA_W  = 10,
    parameter int WIN     = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_COL*DATA_W-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIN*DATA_W-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef RF2D_WIN_SUM_EN
    output logic [DATA_W+$clog2(WIN):0] out_sum,
`endif
    output logic [$clog2(NUM_COL)-1:0]  out_col
);

    localparam int COL_W = $clog2(NUM_COL);
    localparam int CNT_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

    typedef enum logic [1:0] {FILL, SCAN, LOAD} state_t;

    logic [NUM_ROW-1:0][NUM_COL-1:0][DATA_W-1:0] mem_q, mem_d;
    state_t                                       state_q, state_d;
    logic [CNT_W-1:0]                             fill_cnt_q, fill_cnt_d;
    logic [COL_W-1:0]                             out_col_q, out_col_d;
    logic                                         out_valid_q, out_valid_d;
    logic                                         in_ready_q, in_ready_d;
    logic                                         row_shift, col_shift;

    // Accepts are exclusive by state because in_ready/out_valid are never both high.
    assign row_shift = in_valid & in_ready_q;
    assign col_shift = out_valid_q & out_ready;

    always_comb begin
        mem_d      = mem_q;
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        out_col_d  = out_col_q;
        if (flush) begin
            mem_d      = '0;
            state_d    = FILL;
            fill_cnt_d = '0;
            out_col_d  = '0;
        end else begin
            if (row_shift) begin
                for (int unsigned r = 0; r < NUM_ROW - 1; r++)
                    mem_d[r] = mem_q[r+1];
                mem_d[NUM_ROW-1] = in_data;
            end
            if (col_shift) begin
                for (int unsigned r = 0; r < NUM_ROW; r++)
                    for (int unsigned c = 0; c < NUM_COL; c++)
                        mem_d[r][c] = mem_q[r][(c + 1) % NUM_COL];
            end
            case (state_q)
                FILL: if (row_shift) begin
                    if (fill_cnt_q == CNT_W'(NUM_ROW - 1)) begin
                        state_d    = SCAN;
                        fill_cnt_d = '0;
                        out_col_d  = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                SCAN: if (col_shift) begin
                    if (out_col_q == COL_W'(NUM_COL - 1)) begin
                        state_d   = LOAD;
                        out_col_d = '0;
                    end else begin
                        out_col_d = out_col_q + 1'b1;
                    end
                end
                LOAD: if (row_shift) state_d = SCAN;
                default: state_d = FILL;
            endcase
        end
        out_valid_d = (state_d == SCAN);
        in_ready_d  = (state_d != SCAN);
    end

`ifdef RF2D_WIN_SUM_EN
    logic [DATA_W+$clog2(WIN):0] sum_q, sum_d;

    always_comb begin
        sum_d = '0;
        for (int unsigned w = 0; w < WIN; w++)
            sum_d = sum_d + (DATA_W+$clog2(WIN)+1)'(mem_d[w][0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign out_sum = sum_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q       <= '0;
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            mem_q       <= mem_d;
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        for (int unsigned w = 0; w < WIN; w++)
            out_data[w*DATA_W +: DATA_W] = mem_q[w][0];
    end

    assign out_col   = out_col_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_rf2d_window.sv
// Scoreboard bench for rf2d_window: a row-id/column-offset model predicts outputs after every edge.
module tb_rf2d_window;
    localparam int NC = 18;
    localparam int NR = 16;
    localparam int DW = 10;
    localparam int W  = 3;
    localparam int CW = $clog2(NC);
    localparam int SW = DW + $clog2(W) + 1;

    logic           clk = 1'b0;
    logic           reset, flush, in_valid, out_ready;
    logic [NC*DW-1:0] in_data;
    logic           in_ready, out_valid;
    logic [W*DW-1:0] out_data;
    logic [CW-1:0]  out_col;
    logic [SW-1:0]  out_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf2d_window #(.NUM_COL(NC), .NUM_ROW(NR), .DATA_W(DW), .WIN(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef RF2D_WIN_SUM_EN
        .out_sum(out_sum),
`endif
        .out_col(out_col)
    );

`ifndef RF2D_WIN_SUM_EN
    assign out_sum = '0;
`endif

    typedef struct {
        logic          v;
        logic          r;
        logic [W*DW-1:0] d;
        logic [CW-1:0] c;
        logic [SW-1:0] s;
    } exp_t;

    exp_t sb[$];

    // Model: each stored row is an id (-1 = cleared), rotation tracked as a column offset.
    int m_rows[NR];
    int m_state;  // 0 FILL, 1 SCAN, 2 LOAD
    int m_col, m_fill;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(int id, int c);
        if (id < 0) return '0;
        return DW'((id * 32 + c) & ((1 << DW) - 1));
    endfunction

    function automatic logic [NC*DW-1:0] row_bits(int id);
        logic [NC*DW-1:0] b;
        for (int c = 0; c < NC; c++) b[c*DW +: DW] = elem(id, c);
        return b;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) m_rows[r] = -1;
        m_state = 0;
        m_col   = 0;
        m_fill  = 0;
    endfunction

    function automatic void model_shift(int id);
        for (int r = 0; r < NR - 1; r++) m_rows[r] = m_rows[r+1];
        m_rows[NR-1] = id;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.v = (m_state == 1);
        e.r = (m_state != 1);
        e.c = CW'(m_col);
        e.s = '0;
        for (int w = 0; w < W; w++) begin
            e.d[w*DW +: DW] = elem(m_rows[w], m_col);
            e.s = e.s + SW'(elem(m_rows[w], m_col));
        end
        return e;
    endfunction

    task automatic step(input bit iv, input int id, input bit ordy, input bit fl);
        exp_t e;
        in_valid  = iv;
        in_data   = row_bits(id);
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (iv) begin
                    model_shift(id);
                    if (m_fill == NR - 1) begin m_state = 1; m_fill = 0; m_col = 0; end
                    else m_fill++;
                end
                1: if (ordy) begin
                    if (m_col == NC - 1) begin m_state = 2; m_col = 0; end
                    else m_col++;
                end
                default: if (iv) begin model_shift(id); m_state = 1; end
            endcase
        end
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_valid", 64'(out_valid), 64'(e.v));
        check("in_ready",  64'(in_ready),  64'(e.r));
        check("out_data",  64'(out_data),  64'(e.d));
        check("out_col",   64'(out_col),   64'(e.c));
`ifdef RF2D_WIN_SUM_EN
        check("out_sum",   64'(out_sum),   64'(e.s));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ready"}, 64'(in_ready),  64'd1);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_col"},   64'(out_col),   64'd0);
`ifdef RF2D_WIN_SUM_EN
        check({tag, "_sum"},   64'(out_sum),   64'd0);
`endif
    endtask

    initial begin
        int id;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        #1;
        check_reset_outputs("rst0");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;

        // Fill rows 0..15 with random (ignored) out_ready.
        for (int i = 0; i < NR; i++) step(1'b1, i, 1'($urandom_range(0, 1)), 1'b0);
        check("first_frame_d", 64'(out_data), 64'({10'd64, 10'd32, 10'd0}));

        // Full scan with in_valid high (ignored in SCAN), ending in LOAD.
        for (int i = 0; i < NC; i++) step(1'b1, 99, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);

        step(1'b1, 16, 1'b0, 1'b0);
        check("load_frame_d", 64'(out_data), 64'({10'd96, 10'd64, 10'd32}));

        // Advance to column 5, then hold under backpressure.
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 77, 1'b0, 1'b0);

        // Flush overrides concurrent accepts.
        step(1'b1, 55, 1'b1, 1'b1);
        id = 17;
        for (int i = 0; i < NR; i++) begin step(1'b1, id, 1'b0, 1'b0); id++; end
        for (int i = 0; i < NC; i++) step(1'b0, 0, 1'($urandom_range(0, 1)) | (i[0]), 1'b0);
        while (m_state == 1 && n_tests < 5000) step(1'b0, 0, 1'b1, 1'b0);
        check("in_load", 64'(m_state), 64'd2);

        // Asynchronous reset pulse between edges while in LOAD.
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_async");
        #1 reset = 1'b0;
        model_reset();

        for (int i = 0; i < NR; i++) begin step(1'b1, id, 1'b0, 1'b0); id++; end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
